// File: rtl/vx_sdp_ram_clr.sv
// Simple-dual-port RAM with per-lane write enables, selectable read-during-write
// policy, optional output register, and a clear sweep after reset or on flush.
module vx_sdp_ram_clr #(
  parameter int               DATAW          = 32,
  parameter int               SIZE           = 16,
  parameter int               WRENW          = 4,
  parameter int               OUT_REG        = 0,
  parameter int               RDW_MODE       = 0,
  parameter int               CLEAR_ON_RESET = 1,
  parameter logic [DATAW-1:0] INIT_VALUE     = '0,
  parameter int               ADDRW          = $clog2(SIZE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  output logic             ready,
  input  logic [WRENW-1:0] wren,
  input  logic [ADDRW-1:0] waddr,
  input  logic [DATAW-1:0] wdata,
  input  logic             read,
  input  logic [ADDRW-1:0] raddr,
  output logic             rvalid,
  output logic [DATAW-1:0] rdata
);

  localparam int               LW     = DATAW / WRENW;
  localparam logic [ADDRW:0]   SIZE_A = (ADDRW+1)'(SIZE);
  localparam logic [ADDRW-1:0] LAST   = ADDRW'(SIZE - 1);

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t           state;
  logic [ADDRW-1:0] cnt;
  logic [DATAW-1:0] ram [SIZE];

  logic             wr_en;
  logic             rd_acc;
  logic [DATAW-1:0] rd_word;
  logic             s1_valid;
  logic [DATAW-1:0] s1_data;

  assign wr_en  = ready && ({1'b0, waddr} < SIZE_A);
  assign rd_acc = ready && read;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      case (state)
        S_CLEAR: begin
          if (flush) begin
            cnt <= '0;
          end else if (cnt == LAST) begin
            state <= S_READY;
            ready <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (flush) begin
            state <= S_CLEAR;
            cnt   <= '0;
            ready <= 1'b0;
          end else begin
            ready <= 1'b1;
          end
        end
      endcase
    end
  end

  // Storage is never reset; the sweep owns the array while ready is low.
  always_ff @(posedge clk) begin
    if (!reset && state == S_CLEAR) begin
      ram[cnt] <= INIT_VALUE;
    end else if (wr_en) begin
      for (int unsigned i = 0; i < WRENW; i++) begin
        if (wren[i]) ram[waddr][i*LW +: LW] <= wdata[i*LW +: LW];
      end
    end
  end

  always_comb begin
    rd_word = INIT_VALUE;
    if ({1'b0, raddr} < SIZE_A) begin
      rd_word = ram[raddr];
      if (RDW_MODE != 0 && wr_en && waddr == raddr) begin
        for (int unsigned i = 0; i < WRENW; i++) begin
          if (wren[i]) rd_word[i*LW +: LW] = wdata[i*LW +: LW];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_acc;
      if (rd_acc) s1_data <= rd_word;
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic             s2_valid;
    logic [DATAW-1:0] s2_data;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        s2_valid <= 1'b0;
        s2_data  <= '0;
      end else begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_data <= s1_data;
      end
    end

    assign rvalid = s2_valid;
    assign rdata  = s2_data;
  end else begin : g_noreg
    assign rvalid = s1_valid;
    assign rdata  = s1_data;
  end

endmodule

// File: tb/tb_vx_sdp_ram_clr.sv
// Three differently configured RAMs share one stimulus stream and are checked
// every cycle against an array/countdown reference model.
module tb_vx_sdp_ram_clr;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic [3:0]  wren = '0;
  logic [3:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic        read = 1'b0;
  logic [3:0]  raddr = '0;

  logic [2:0]       rdy;
  logic [2:0]       rvld;
  logic [2:0][31:0] rdat;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // k=0: base config; k=1: 12 entries, registered output, new-data RDW, 5A init; k=2: no clear on reset
  vx_sdp_ram_clr #(.DATAW(32), .SIZE(16), .WRENW(4), .OUT_REG(0), .RDW_MODE(0),
                   .CLEAR_ON_RESET(1), .INIT_VALUE(32'h0)) dut0 (
    .clk(clk), .reset(reset), .flush(flush), .ready(rdy[0]), .wren(wren), .waddr(waddr),
    .wdata(wdata), .read(read), .raddr(raddr), .rvalid(rvld[0]), .rdata(rdat[0]));

  vx_sdp_ram_clr #(.DATAW(32), .SIZE(12), .WRENW(4), .OUT_REG(1), .RDW_MODE(1),
                   .CLEAR_ON_RESET(1), .INIT_VALUE(32'h5A5A5A5A)) dut1 (
    .clk(clk), .reset(reset), .flush(flush), .ready(rdy[1]), .wren(wren), .waddr(waddr),
    .wdata(wdata), .read(read), .raddr(raddr), .rvalid(rvld[1]), .rdata(rdat[1]));

  vx_sdp_ram_clr #(.DATAW(32), .SIZE(16), .WRENW(4), .OUT_REG(0), .RDW_MODE(1),
                   .CLEAR_ON_RESET(0), .INIT_VALUE(32'h0)) dut2 (
    .clk(clk), .reset(reset), .flush(flush), .ready(rdy[2]), .wren(wren), .waddr(waddr),
    .wdata(wdata), .read(read), .raddr(raddr), .rvalid(rvld[2]), .rdata(rdat[2]));

  function automatic int p_size(int k); return (k == 1) ? 12 : 16; endfunction
  function automatic int p_lat(int k); return (k == 1) ? 2 : 1; endfunction
  function automatic bit p_rdw(int k); return k != 0; endfunction
  function automatic bit p_clr(int k); return k != 2; endfunction
  function automatic logic [31:0] p_init(int k); return (k == 1) ? 32'h5A5A5A5A : 32'h0; endfunction
  function automatic logic [31:0] lane_mask(logic [3:0] w);
    return {{8{w[3]}}, {8{w[2]}}, {8{w[1]}}, {8{w[0]}}};
  endfunction

  logic [31:0] mmem [3][16];
  bit          mk   [3][16];
  int          clr_left [3];
  bit          e_rdy [3];
  bit          e_rv  [3];
  logic [31:0] e_rd  [3];
  bit          e_known [3];
  bit          sv [3][4];
  logic [31:0] sd [3][4];
  bit          sk [3][4];
  int          cyc = 0;

  task automatic chk(string tag, int k, logic [31:0] got, logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s[dut%0d] observed %h expected %h at %0t", tag, k, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      e_rdy[k] = 0; e_rv[k] = 0; e_rd[k] = '0; e_known[k] = 1;
      clr_left[k] = p_clr(k) ? p_size(k) : 0;
      for (int j = 0; j < 4; j++) sv[k][j] = 0;
    end
  endtask

  task automatic model_edge(int k);
    int s;
    int slot;
    logic [31:0] m;
    logic [31:0] v;
    bit acc, wr, vk;
    s   = p_size(k);
    m   = lane_mask(wren);
    acc = e_rdy[k] && read;
    wr  = e_rdy[k] && (int'(waddr) < s);
    if (int'(raddr) >= s) begin
      v = p_init(k); vk = 1;
    end else begin
      v = mmem[k][raddr]; vk = mk[k][raddr];
      if (p_rdw(k) && wr && waddr == raddr) begin
        v  = (v & ~m) | (wdata & m);
        vk = vk || (wren == 4'hF);
      end
    end
    if (acc) begin
      slot = (cyc + p_lat(k) - 1) % 4;
      sv[k][slot] = 1; sd[k][slot] = v; sk[k][slot] = vk;
    end
    slot = cyc % 4;
    e_rv[k] = sv[k][slot];
    if (sv[k][slot]) begin e_rd[k] = sd[k][slot]; e_known[k] = sk[k][slot]; end
    sv[k][slot] = 0;
    if (wr) begin
      mmem[k][waddr] = (mmem[k][waddr] & ~m) | (wdata & m);
      mk[k][waddr]   = mk[k][waddr] || (wren == 4'hF);
    end
    if (clr_left[k] > 0) begin
      mmem[k][s - clr_left[k]] = p_init(k);
      mk[k][s - clr_left[k]]   = 1;
      if (flush) clr_left[k] = s;
      else begin
        clr_left[k]--;
        if (clr_left[k] == 0) e_rdy[k] = 1;
      end
    end else if (flush) begin
      clr_left[k] = s; e_rdy[k] = 0;
    end else begin
      e_rdy[k] = 1;
    end
  endtask

  task automatic check_now();
    for (int k = 0; k < 3; k++) begin
      chk("ready", k, 32'(rdy[k]), 32'(e_rdy[k]));
      chk("rvalid", k, 32'(rvld[k]), 32'(e_rv[k]));
      if (e_known[k]) chk("rdata", k, rdat[k], e_rd[k]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      cyc++;
      for (int k = 0; k < 3; k++) model_edge(k);
    end
    #1;
    check_now();
  endtask

  task automatic release_and_sweep(output int n);
    reset = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
      if (n == 1) chk("noclear_ready", 2, 32'(rdy[2]), 32'd1);
    end while (!rdy[0] && n < 60);
  endtask

  initial begin
    int n;
    for (int k = 0; k < 3; k++)
      for (int a = 0; a < 16; a++) begin mmem[k][a] = '0; mk[k][a] = 0; end
    model_reset();

    #1;
    check_now();
    repeat (3) tick();
    release_and_sweep(n);
    chk("reset_sweep_len", 0, n, 16);

    for (int a = 0; a < 16; a++) begin read = 1'b1; raddr = 4'(a); tick(); end
    read = 1'b0;
    repeat (2) tick();

    waddr = 4'd3; wdata = 32'hAABBCCDD; wren = 4'b1111; tick();
    wdata = 32'h11223344; wren = 4'b0101; tick();
    wren = '0; read = 1'b1; raddr = 4'd3; tick();
    chk("lane_merge", 0, rdat[0], 32'hAA22CC44);
    chk("lane_merge", 2, rdat[2], 32'hAA22CC44);
    read = 1'b0; tick();
    chk("lane_merge_oreg", 1, rdat[1], 32'hAA22CC44);

    waddr = 4'd5; wdata = 32'h0; wren = 4'hF; tick();
    wdata = 32'hDEADBEEF; wren = 4'b0011; read = 1'b1; raddr = 4'd5; tick();
    chk("rdw_old", 0, rdat[0], 32'h00000000);
    chk("rdw_new", 2, rdat[2], 32'h0000BEEF);
    wren = '0; tick();
    chk("rdw_after", 0, rdat[0], 32'h0000BEEF);
    chk("rdw_new_oreg", 1, rdat[1], 32'h0000BEEF);
    read = 1'b0; tick();
    chk("rdw_after_oreg", 1, rdat[1], 32'h0000BEEF);
    repeat (2) tick();

    read = 1'b1; raddr = 4'd1; tick();
    chk("oreg_lat_n1", 1, 32'(rvld[1]), 32'd0);
    raddr = 4'd2; tick();
    chk("oreg_lat_n2", 1, 32'(rvld[1]), 32'd1);
    raddr = 4'd3; tick();
    read = 1'b0; tick();
    tick();
    chk("oreg_idle", 1, 32'(rvld[1]), 32'd0);

    for (int i = 0; i < 300; i++) begin
      wren  = 4'($urandom);
      waddr = 4'($urandom);
      wdata = $urandom;
      read  = ($urandom_range(0, 1) == 1);
      raddr = 4'($urandom);
      flush = ($urandom_range(0, 39) == 0);
      tick();
    end
    flush = 1'b0; wren = '0; read = 1'b0;
    repeat (30) tick();

    flush = 1'b1; read = 1'b1; raddr = 4'd3; tick();
    flush = 1'b0;
    n = 0;
    do begin raddr = 4'($urandom); tick(); n++; end while (!rdy[0] && n < 60);
    chk("flush_window", 0, n, 16);
    for (int a = 0; a < 16; a++) begin raddr = 4'(a); tick(); end
    read = 1'b0;
    repeat (2) tick();

    flush = 1'b1; tick();
    n = 0;
    do begin flush = (n == 6); tick(); n++; end while (!rdy[0] && n < 60);
    flush = 1'b0;
    chk("reflush_window", 0, n, 23);
    repeat (4) tick();

    read = 1'b1; raddr = 4'd2; tick();
    read = 1'b0; flush = 1'b1; tick();
    flush = 1'b0;
    repeat (9) tick();
    #2 reset = 1'b1;
    model_reset();
    #1;
    check_now();
    chk("async_rdata", 1, rdat[1], 32'h0);
    repeat (2) tick();
    release_and_sweep(n);
    chk("post_abort_sweep_len", 0, n, 16);
    for (int a = 0; a < 16; a++) begin read = 1'b1; raddr = 4'(a); tick(); end
    read = 1'b0;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
